// File: rtl/note_pkg.sv
// Shared types and constants for the note judge: FSM states, note width and
// multiplier stepping, plus the streak-to-multiplier mapping.
package note_pkg;

  typedef enum logic [0:0] {
    J_IDLE  = 1'b0,
    J_ARMED = 1'b1
  } judge_state_t;

  localparam int unsigned NOTE_W      = 5;
  localparam logic [2:0]  MULT_MAX    = 3'd4;
  localparam int unsigned STREAK_STEP = 8;

  // One multiplier step per STREAK_STEP consecutive hits, capped at MULT_MAX.
  function automatic logic [2:0] mult_of(input logic [7:0] streak);
    int unsigned steps;
    steps = 32'(streak) / STREAK_STEP;
    if (steps + 1 >= 32'(MULT_MAX)) return MULT_MAX;
    return 3'(steps + 1);
  endfunction

endpackage

// File: rtl/input_sync.sv
// Two-flop synchronizer for a bundle of asynchronous buttons. The MSB is also
// rising-edge detected; the remaining bits are delivered as aligned levels.
module input_sync #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] i_d,
  output logic [W-2:0] o_level,
  output logic         o_edge
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  logic [W-1:0] r_s3;
  logic         r_edge;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, which is what makes a shift chain work.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_s3   <= '0;
      r_edge <= 1'b0;
    end else begin
      r_s1   <= i_d;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_edge <= r_s2[W-1] & ~r_s3[W-1];
    end
  end

  // Levels come from r_s3 so they line up with the cycle r_edge is high.
  assign o_level = r_s3[W-2:0];
  assign o_edge  = r_edge;

endmodule

// File: rtl/note_judge.sv
// Judges strums against the expected-note stream and keeps score/streak.
// Optional build macro NOTE_JUDGE_OVERSTRUM_EN: strums with no note pending count as misses.
module note_judge
  import note_pkg::*;
#(
  parameter logic [23:0] WINDOW_CYC = 24'd5_000_000,
  parameter int unsigned NOTE_LAG   = 2,
  parameter logic [15:0] HIT_PTS    = 16'd10
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              eight_beat,
  input  logic              load,
  input  logic [NOTE_W-1:0] exp_notes,
  input  logic [NOTE_W-1:0] frets,
  input  logic              strum,
  output logic              hit,
  output logic              miss,
  output logic [15:0]       score,
  output logic [7:0]        streak,
  output logic [2:0]        multiplier
);

  logic [NOTE_W-1:0] w_frets;
  logic              w_strum_ev;

  input_sync #(.W(NOTE_W + 1)) u_sync (
    .clk     (clk),
    .resetn  (resetn),
    .i_d     ({strum, frets}),
    .o_level (w_frets),
    .o_edge  (w_strum_ev)
  );

  judge_state_t      r_state, w_state_nxt;
  logic [NOTE_W-1:0] r_pending, w_pending_nxt;
  logic [23:0]       r_cnt, w_cnt_nxt;
  logic [NOTE_LAG-1:0] r_lag;
  logic              w_arrive;
  logic              w_hit_nxt, w_miss_nxt;
  logic              r_hit, r_miss, r_load_d;
  logic [15:0]       r_score;
  logic [7:0]        r_streak;
  logic [18:0]       w_gain;
  logic [19:0]       w_sum;

  // Sample point trails each step strobe by NOTE_LAG clocks.
  assign w_arrive = load && r_lag[NOTE_LAG-1] && (exp_notes != '0);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_cnt_nxt     = r_cnt;
    w_hit_nxt     = 1'b0;
    w_miss_nxt    = 1'b0;
    if (!load) begin
      w_state_nxt   = J_IDLE;
      w_pending_nxt = '0;
      w_cnt_nxt     = '0;
    end else begin
      case (r_state)
        J_IDLE: begin
`ifdef NOTE_JUDGE_OVERSTRUM_EN
          if (w_strum_ev) w_miss_nxt = 1'b1;
`endif
        end
        J_ARMED: begin
          if (w_strum_ev) begin
            w_hit_nxt     = (w_frets == r_pending);
            w_miss_nxt    = (w_frets != r_pending);
            w_state_nxt   = J_IDLE;
            w_pending_nxt = '0;
            w_cnt_nxt     = '0;
          end else if (w_arrive || r_cnt == '0) begin
            // A superseded or expired note is a miss.
            w_miss_nxt    = 1'b1;
            w_state_nxt   = J_IDLE;
            w_pending_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt - 24'd1;
          end
        end
        default: w_state_nxt = J_IDLE;
      endcase
      // A new note arms after any judgement of the old one in the same cycle.
      if (w_arrive) begin
        w_state_nxt   = J_ARMED;
        w_pending_nxt = exp_notes;
        w_cnt_nxt     = WINDOW_CYC;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= J_IDLE;
      r_pending <= '0;
      r_cnt     <= '0;
      r_lag     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_cnt     <= w_cnt_nxt;
      if (!load) r_lag <= '0;
      else       r_lag <= NOTE_LAG'({r_lag, eight_beat});
    end
  end

  assign w_gain = 19'(HIT_PTS) * 19'(multiplier);
  assign w_sum  = 20'(r_score) + 20'(w_gain);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
      r_load_d <= 1'b0;
      r_score  <= '0;
      r_streak <= '0;
    end else begin
      r_hit    <= w_hit_nxt;
      r_miss   <= w_miss_nxt;
      r_load_d <= load;
      if (load && !r_load_d) begin
        r_score  <= '0;
        r_streak <= '0;
      end else if (w_hit_nxt) begin
        r_score  <= (w_sum > 20'h0FFFF) ? 16'hFFFF : w_sum[15:0];
        r_streak <= (r_streak == 8'hFF) ? r_streak : r_streak + 8'd1;
      end else if (w_miss_nxt) begin
        r_streak <= '0;
      end
    end
  end

  assign hit        = r_hit;
  assign miss       = r_miss;
  assign score      = r_score;
  assign streak     = r_streak;
  assign multiplier = mult_of(r_streak);

endmodule
